// File: rtl/sum_accumulator.sv
// ---------------------------------------------------------------------------
// sum_accumulator
//
// Downstream stage of the hierarchical adder. Adds DEPTH consecutive valid
// (WIDTH+1)-bit sums into one frame total and offers that total on a
// valid/ready handshake. A sum that arrives while a finished total is still
// waiting for the consumer is discarded, and the sticky 'dropped' flag is set.
//
// Ports
//   clk        single clock, all state changes on the rising edge
//   rst        asynchronous reset, active low
//   clear      synchronous frame abort, active high, highest priority
//   sum_in     sum word from the adder (WIDTH+1 bits)
//   sum_valid  sum_in is valid this cycle (the adder cannot be stalled)
//   acc_out    frame total, stable while acc_valid is high
//   acc_valid  frame total available
//   acc_ready  consumer takes acc_out when acc_valid & acc_ready
//   fill       number of sums accumulated in the current frame
//   dropped    sticky flag, a sum was discarded since the last clear/reset
// ---------------------------------------------------------------------------
module sum_accumulator #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4
) (
   input  logic                                 clk,
   input  logic                                 rst,
   input  logic                                 clear,
   input  logic [WIDTH:0]                       sum_in,
   input  logic                                 sum_valid,
   output logic [WIDTH+1+$clog2(DEPTH)-1:0]     acc_out,
   output logic                                 acc_valid,
   input  logic                                 acc_ready,
   output logic [$clog2(DEPTH):0]               fill,
   output logic                                 dropped
);

   // Total width leaves room for DEPTH maximal sums, so no wrap can occur.
   localparam int ACC_W = WIDTH + 1 + $clog2(DEPTH);
   localparam int CNT_W = $clog2(DEPTH) + 1;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ACCUM = 2'd1,
      HOLD  = 2'd2
   } state_t;

   state_t           state_q, state_d;
   logic [ACC_W-1:0] acc_q, acc_d;
   logic [CNT_W-1:0] fill_q, fill_d;
   logic             valid_q, valid_d;
   logic             dropped_q, dropped_d;

   logic [ACC_W-1:0] sum_ext;
   logic [CNT_W-1:0] fill_inc;

   assign sum_ext  = ACC_W'(sum_in);
   assign fill_inc = fill_q + CNT_W'(1);

   // State and every output live in flops; the asynchronous reset throws away
   // any partial or pending total immediately, without waiting for an edge.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q   <= IDLE;
         acc_q     <= '0;
         fill_q    <= '0;
         valid_q   <= 1'b0;
         dropped_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         acc_q     <= acc_d;
         fill_q    <= fill_d;
         valid_q   <= valid_d;
         dropped_q <= dropped_d;
      end
   end

   // Next-state and next-output logic. Everything holds by default; clear
   // overrides all other events, including a handshake in the same cycle.
   // In HOLD a simultaneous handshake and new sum starts the next frame
   // directly, which is what lets back-to-back frames run without a bubble.
   always_comb begin
      state_d   = state_q;
      acc_d     = acc_q;
      fill_d    = fill_q;
      valid_d   = valid_q;
      dropped_d = dropped_q;

      if (clear) begin
         state_d   = IDLE;
         acc_d     = '0;
         fill_d    = '0;
         valid_d   = 1'b0;
         dropped_d = 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               if (sum_valid) begin
                  acc_d   = sum_ext;
                  fill_d  = CNT_W'(1);
                  state_d = ACCUM;
               end
            end

            ACCUM: begin
               if (sum_valid) begin
                  acc_d  = acc_q + sum_ext;
                  fill_d = fill_inc;
                  if (fill_inc == CNT_W'(DEPTH)) begin
                     state_d = HOLD;
                     valid_d = 1'b1;
                  end
               end
            end

            HOLD: begin
               if (acc_ready) begin
                  valid_d = 1'b0;
                  if (sum_valid) begin
                     acc_d   = sum_ext;
                     fill_d  = CNT_W'(1);
                     state_d = ACCUM;
                  end else begin
                     acc_d   = '0;
                     fill_d  = '0;
                     state_d = IDLE;
                  end
               end else if (sum_valid) begin
                  dropped_d = 1'b1;
               end
            end

            default: begin
               state_d = IDLE;
               acc_d   = '0;
               fill_d  = '0;
               valid_d = 1'b0;
            end
         endcase
      end
   end

   assign acc_out   = acc_q;
   assign acc_valid = valid_q;
   assign fill      = fill_q;
   assign dropped   = dropped_q;

endmodule
